mem_handshake_master: RTL and testbench
=======================================

MEM_HANDSHAKE_MASTER -- requirements
Module: mem_handshake_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum wait cycles for MOC (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have ports:
- Clk  in  1  clock, rising edge.
- Clr  in  1  reset, asynchronous, active-high.
- Req  in  1  access request from the control unit.
- Rw  in  1  direction: 1 read, 0 write.
- Size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
- SignExt  in  1  sign-extend halfword/byte read data.
- Addr  in  32  byte address.
- WData  in  32  write data, right-justified.
- MOC  in  1  memory operation complete.
- MemDataOut  in  32  read data from RAM.
- MOV  out  1  memory operation valid strobe.
- ReadWrite  out  1  RAM direction, 1 read.
- MemOp  out  6  RAM size opcode.
- MemAddr  out  32  RAM address.
- MemDataIn  out  32  RAM write data.
- RData  out  32  extended read data.
- Busy  out  1  transaction in progress.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  error flag, valid with Done.

Function
REQ-003 SHALL implement FSM states IDLE, SETUP, STROBE, WAIT, FINISH; Busy=1 in every state except IDLE.
REQ-004 In IDLE with Req=1 at a rising edge, SHALL capture Rw, Size, SignExt, Addr and WData, then go to SETUP; Req while Busy=1 SHALL be ignored.
REQ-005 In SETUP, SHALL drive MemAddr, MemDataIn, ReadWrite and MemOp from the captured request with MOV=0, then go to STROBE.
REQ-006 MemOp encoding:
- Reads: word 100011, halfword 100001, byte 100000.
- Writes: word 101011, halfword 101001, byte 101000.
REQ-007 In STROBE, SHALL raise MOV=1, then go to WAIT; MOC SHALL NOT be sampled in STROBE.
REQ-008 In WAIT, SHALL hold MOV=1 and all Mem* outputs stable; the first edge with MOC=1 SHALL move to FINISH and, for a read, load RData.
REQ-009 In FINISH, SHALL drive MOV=0 and Done=1 for exactly one cycle, then return to IDLE.
REQ-010 Minimum latency: Req sampled at edge k, Done high in the cycle after edge k+3.
REQ-011 Read extension:
- Word: RData=MemDataOut.
- Halfword: bits 31:16 replicate bit 15 if SignExt=1, else zero.
- Byte: bits 31:8 replicate bit 7 if SignExt=1, else zero.
REQ-012 Writes SHALL leave RData unchanged.
REQ-013 Misalignment (word with Addr[1:0]!=0, halfword with Addr[0]=1) or Size=11 SHALL skip SETUP/STROBE/WAIT, go directly to FINISH with Err=1, and never raise MOV.
REQ-014 Err SHALL be 0 on every successful Done.

Reset
REQ-015 Clr=1 SHALL immediately force state IDLE and drive MOV=0, Done=0, Err=0, Busy=0, RData=0, MemAddr=0, MemDataIn=0, MemOp=0, ReadWrite=1.
REQ-016 Clr asserted mid-transaction SHALL abort it with no Done pulse.

Configuration
REQ-017 With MEM_TIMEOUT_EN defined, a counter SHALL run in WAIT. After TIMEOUT_CYCLES consecutive WAIT cycles with MOC=0, the block SHALL go to FINISH with Err=1, MOV=0, and RData unchanged. The counter SHALL clear on entry to WAIT.
REQ-018 Without MEM_TIMEOUT_EN, WAIT SHALL persist until MOC=1, and no counter logic SHALL exist.

Structure
REQ-019 Package mem_pkg SHALL hold the MemOp opcode constants, the Size encodings and the FSM state typedef.
REQ-020 Read-data extension SHALL be the combinational sub-module rdata_extend (inputs: data, size, signext).

Verification
REQ-021 Word read with Addr=0x10 and MOC tied 1 -> MemOp=100011, ReadWrite=1, one MOV pulse, Done 4 cycles after Req, RData=MemDataOut.
REQ-022 Byte read with MemDataOut=0x00000080 -> RData=0xFFFFFF80 with SignExt=1 and 0x00000080 with SignExt=0.
REQ-023 Halfword write with Addr=0x3 -> no MOV, Done=1 with Err=1 one cycle after capture; Size=11 gives the same response.
REQ-024 Word write with MOC held 0 for 5 WAIT cycles -> MOV stays 1 with MemAddr/MemDataIn/MemOp=101011 stable, then Done with Err=0; Req pulsed during WAIT is ignored.
REQ-025 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, MOC stuck 0 -> Done=1, Err=1, MOV=0 after 4 WAIT cycles.
REQ-026 Clr asserted in WAIT -> MOV=0 and Busy=0 immediately, no Done; the next Req completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory handshake master.
//   - size_e   : access size encodings (byte, halfword, word, illegal)
//   - state_e  : handshake FSM states
//   - OP_*     : RAM MemOp opcodes
//   - mem_opcode() maps direction + size to an opcode
//   - is_illegal() flags misaligned or illegal-size requests
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_FINISH
  } state_e;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_LH = 6'b100001;
  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SB = 6'b101000;

  function automatic logic [5:0] mem_opcode(input logic rw, input size_e sz);
    case (sz)
      SZ_WORD: return rw ? OP_LW : OP_SW;
      SZ_HALF: return rw ? OP_LH : OP_SH;
      default: return rw ? OP_LB : OP_SB;
    endcase
  endfunction

  function automatic logic is_illegal(input size_e sz, input logic [1:0] a);
    case (sz)
      SZ_WORD: return a != 2'b00;
      SZ_HALF: return a[0];
      SZ_ILL:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rdata_extend.sv
// Combinational read-data extension.
//   data    : raw 32-bit RAM read data
//   size    : access size (byte / halfword / word)
//   signext : 1 = sign-extend sub-word data, 0 = zero-extend
//   ext     : right-justified, extended result
module rdata_extend
  import mem_pkg::*;
(
  input  logic [31:0] data,
  input  size_e       size,
  input  logic        signext,
  output logic [31:0] ext
);

  always_comb begin
    ext = data;
    case (size)
      SZ_BYTE: ext = {{24{signext & data[7]}},  data[7:0]};
      SZ_HALF: ext = {{16{signext & data[15]}}, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/mem_handshake_master.sv
// Memory handshake master: turns a single request from the control unit
// into a SETUP / STROBE / WAIT / FINISH handshake with the RAM.
//   Clk, Clr          : clock (rising edge), async active-high reset
//   Req, Rw, Size,
//   SignExt, Addr,
//   WData             : request, captured only while idle
//   MOC, MemDataOut   : RAM completion and read data
//   MOV, ReadWrite,
//   MemOp, MemAddr,
//   MemDataIn         : RAM strobe, direction, opcode, address, write data
//   RData             : extended read data (updated on read completion only)
//   Busy, Done, Err   : status; Err is meaningful while Done is high
// Optional build macro MEM_TIMEOUT_EN adds a WAIT watchdog of
// TIMEOUT_CYCLES cycles that finishes the access with Err=1.
module mem_handshake_master
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Req,
  input  logic        Rw,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic        MOC,
  input  logic [31:0] MemDataOut,
  output logic        MOV,
  output logic        ReadWrite,
  output logic [5:0]  MemOp,
  output logic [31:0] MemAddr,
  output logic [31:0] MemDataIn,
  output logic [31:0] RData,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  state_e      state;
  size_e       cap_size;
  logic        cap_signext;
  logic [31:0] ext_data;
  size_e       req_size;

  assign req_size = size_e'(Size);

  rdata_extend u_ext (
    .data    (MemDataOut),
    .size    (cap_size),
    .signext (cap_signext),
    .ext     (ext_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          timeout;
  // Fires on the TIMEOUT_CYCLES-th consecutive WAIT edge without MOC.
  assign timeout = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state       <= S_IDLE;
      MOV         <= 1'b0;
      Done        <= 1'b0;
      Err         <= 1'b0;
      Busy        <= 1'b0;
      RData       <= '0;
      MemAddr     <= '0;
      MemDataIn   <= '0;
      MemOp       <= '0;
      ReadWrite   <= 1'b1;
      cap_size    <= SZ_BYTE;
      cap_signext <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Req) begin
            Busy <= 1'b1;
            if (is_illegal(req_size, Addr[1:0])) begin
              // Rejected before touching the RAM: MOV never rises.
              state <= S_FINISH;
              Done  <= 1'b1;
              Err   <= 1'b1;
            end else begin
              // Mem* outputs are loaded here so they are valid during SETUP.
              state       <= S_SETUP;
              Err         <= 1'b0;
              MemAddr     <= Addr;
              MemDataIn   <= WData;
              ReadWrite   <= Rw;
              MemOp       <= mem_opcode(Rw, req_size);
              cap_size    <= req_size;
              cap_signext <= SignExt;
            end
          end
        end
        S_SETUP: begin
          MOV   <= 1'b1;
          state <= S_STROBE;
        end
        S_STROBE: begin
          state <= S_WAIT;
`ifdef MEM_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (MOC) begin
            MOV   <= 1'b0;
            Done  <= 1'b1;
            Err   <= 1'b0;
            state <= S_FINISH;
            if (ReadWrite) RData <= ext_data;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout) begin
            MOV   <= 1'b0;
            Done  <= 1'b1;
            Err   <= 1'b1;
            state <= S_FINISH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_FINISH: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
          Err   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_handshake_master.sv
// Self-checking bench for mem_handshake_master: directed cases followed by
// randomized transactions checked against a transaction-level model.
module tb_mem_handshake_master;

  localparam int TO = 4;

  logic        Clk = 1'b0;
  logic        Clr = 1'b0;
  logic        Req = 1'b0;
  logic        Rw = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic        SignExt = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WData = '0;
  logic        MOC = 1'b0;
  logic [31:0] MemDataOut = '0;
  logic        MOV, ReadWrite, Busy, Done, Err;
  logic [5:0]  MemOp;
  logic [31:0] MemAddr, MemDataIn, RData;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl_rdata = '0;

  mem_handshake_master #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Clr(Clr), .Req(Req), .Rw(Rw), .Size(Size), .SignExt(SignExt),
    .Addr(Addr), .WData(WData), .MOC(MOC), .MemDataOut(MemDataOut),
    .MOV(MOV), .ReadWrite(ReadWrite), .MemOp(MemOp), .MemAddr(MemAddr),
    .MemDataIn(MemDataIn), .RData(RData), .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, act, exp);
    end
  endtask

  function automatic logic [5:0] op_model(input logic rw, input logic [1:0] sz);
    case ({rw, sz})
      3'b1_10: return 6'b100011;
      3'b1_01: return 6'b100001;
      3'b1_00: return 6'b100000;
      3'b0_10: return 6'b101011;
      3'b0_01: return 6'b101001;
      default: return 6'b101000;
    endcase
  endfunction

  function automatic logic [31:0] ext_model(input logic [1:0] sz, input logic sx,
                                            input logic [31:0] d);
    longint v;
    case (sz)
      2'b00: begin v = d % 256;   if (sx && v >= 128)   v = v - 256;   end
      2'b01: begin v = d % 65536; if (sx && v >= 32768) v = v - 65536; end
      default: v = d;
    endcase
    return 32'(v);
  endfunction

  // delay = WAIT edges with MOC=0 before MOC=1; early = MOC also high
  // during SETUP/STROBE; req_pulse = inject a stray Req during WAIT.
  task automatic run_txn(input logic rw, input logic [1:0] sz, input logic sx,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] md, input int delay,
                         input logic early, input logic req_pulse);
    logic legal, to_err, first, got_err;
    int w, done_at, mov_cnt, busy_low, unstable;
    logic [70:0] rec;
    legal = !(sz == 2'b11 || (sz == 2'b10 && addr[1:0] != 2'b00) ||
              (sz == 2'b01 && addr[0]));
    to_err = 1'b0;
    w = delay + 1;
`ifdef MEM_TIMEOUT_EN
    if (delay >= TO) begin to_err = 1'b1; w = TO; end
`endif
    done_at = -1; mov_cnt = 0; busy_low = 0; unstable = 0; first = 1'b1;
    got_err = 1'b0; rec = '0;
    @(negedge Clk);
    Req = 1'b1; Rw = rw; Size = sz; SignExt = sx; Addr = addr; WData = wd;
    MemDataOut = md; MOC = early;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (MOV) begin
        mov_cnt++;
        if (first) begin rec = {MemOp, MemAddr, MemDataIn, ReadWrite}; first = 1'b0; end
        else if ({MemOp, MemAddr, MemDataIn, ReadWrite} != rec) unstable++;
      end
      if (!Busy) busy_low++;
      if (i == 0 && legal) begin
        chk("setup_mov", 32'(MOV), 32'd0);
        chk("setup_addr", MemAddr, addr);
      end
      Req = req_pulse && (i == 3);
      if (Req) begin Addr = ~addr; WData = ~wd; Rw = ~rw; end
      MOC = early ? (i < 2 || i >= 2 + delay) : (i >= 2 + delay);
      if (Done) begin done_at = i; got_err = Err; break; end
    end
    Req = 1'b0; MOC = 1'b0;
    chk("done_lat", 32'(done_at), legal ? 32'(2 + w) : 32'd0);
    chk("err", 32'(got_err), (legal && !to_err) ? 32'd0 : 32'd1);
    chk("mov_cycles", 32'(mov_cnt), legal ? 32'(1 + w) : 32'd0);
    chk("busy_low", 32'(busy_low), 32'd0);
    if (legal) begin
      chk("mem_stable", 32'(unstable), 32'd0);
      chk("memop", 32'(rec[70:65]), 32'(op_model(rw, sz)));
      chk("memaddr", rec[64:33], addr);
      chk("readwrite", 32'(rec[0]), 32'(rw));
      if (!rw) chk("memdatain", rec[32:1], wd);
      if (rw && !to_err) mdl_rdata = ext_model(sz, sx, md);
    end
    @(negedge Clk);
    chk("idle_busy", 32'(Busy), 32'd0);
    chk("idle_done", 32'(Done), 32'd0);
    chk("rdata", RData, mdl_rdata);
  endtask

  initial begin
    #2 Clr = 1'b1;
    @(negedge Clk);
    chk("rst_mov", 32'(MOV), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_err", 32'(Err), 32'd0);
    chk("rst_rdata", RData, 32'd0);
    chk("rst_addr", MemAddr, 32'd0);
    chk("rst_wdata", MemDataIn, 32'd0);
    chk("rst_memop", 32'(MemOp), 32'd0);
    chk("rst_rw", 32'(ReadWrite), 32'd1);
    Clr = 1'b0;

    // word read, MOC tied high
    run_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hCAFE_BABE, 0, 1'b1, 1'b0);
    // byte read sign / zero extension
    run_txn(1'b1, 2'b00, 1'b1, 32'h21, 32'h0, 32'h0000_0080, 0, 1'b0, 1'b0);
    chk("byte_sx", RData, 32'hFFFF_FF80);
    run_txn(1'b1, 2'b00, 1'b0, 32'h22, 32'h0, 32'h0000_0080, 1, 1'b0, 1'b0);
    chk("byte_zx", RData, 32'h0000_0080);
    // misaligned halfword write, illegal size
    run_txn(1'b0, 2'b01, 1'b0, 32'h3, 32'h1234, 32'h5555_AAAA, 0, 1'b0, 1'b0);
    run_txn(1'b0, 2'b11, 1'b0, 32'h8, 32'h1234, 32'h5555_AAAA, 0, 1'b0, 1'b0);
    // word write, long wait, stray Req during WAIT
    run_txn(1'b0, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'h0, 5, 1'b0, 1'b1);

    // reset while waiting
    @(negedge Clk);
    Req = 1'b1; Rw = 1'b1; Size = 2'b10; Addr = 32'h44; MemDataOut = 32'h1111_2222;
    MOC = 1'b0;
    @(negedge Clk); Req = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("wait_mov", 32'(MOV), 32'd1);
    Clr = 1'b1;
    #1;
    chk("clr_mov", 32'(MOV), 32'd0);
    chk("clr_busy", 32'(Busy), 32'd0);
    chk("clr_done", 32'(Done), 32'd0);
    MOC = 1'b1;
    repeat (2) @(negedge Clk);
    chk("clr_nodone", 32'(Done), 32'd0);
    mdl_rdata = '0;
    Clr = 1'b0; MOC = 1'b0;
    run_txn(1'b1, 2'b01, 1'b1, 32'h46, 32'h0, 32'h0000_9001, 2, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] sz;
      int dly;
      sz = 2'($urandom % 4);
      dly = int'($urandom % 7);
      run_txn(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom,
              dly, 1'($urandom), (dly >= 2) && 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
